// File: rtl/trdb_pkt_arbiter.sv
// trdb_pkt_arbiter
//   Round-robin arbiter that merges the trace packet producers (instruction
//   encoder, user packets, status/timer source) onto the single packet output
//   feeding the host-side sink. It holds one output register, runs a flush
//   sequence that drains the register before trace stops, and keeps a
//   saturating count of packets handed to the sink.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   enable_i           arbitration enable
//   flush_i            drain request (pulse or level)
//   flush_done_o       one-cycle pulse when the drain has completed
//   req_valid_i        per-requester valid
//   req_packet_i       requester k packet at [k*PKT_W +: PKT_W]
//   req_ready_o        per-requester accept (one-hot or zero)
//   pkt_valid_o        output packet valid
//   pkt_data_o         output packet
//   pkt_src_o          requester index of pkt_data_o
//   pkt_ready_i        sink accepts packet
//   busy_o             output register full or flush in progress
//   cnt_clr_i          clear packet counter
//   pkt_count_o        packets handed to sink, saturating
module trdb_pkt_arbiter #(
    parameter int N_REQ = 3,
    parameter int PKT_W = 128,
    parameter int CNT_W = 16,
    parameter int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   flush_i,
    output logic                   flush_done_o,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  logic [N_REQ*PKT_W-1:0] req_packet_i,
    output logic [N_REQ-1:0]       req_ready_o,
    output logic                   pkt_valid_o,
    output logic [PKT_W-1:0]       pkt_data_o,
    output logic [SRC_W-1:0]       pkt_src_o,
    input  logic                   pkt_ready_i,
    output logic                   busy_o,
    input  logic                   cnt_clr_i,
    output logic [CNT_W-1:0]       pkt_count_o
);

    localparam int unsigned NREQ_U = N_REQ;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [SRC_W-1:0] ptr_q;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W-1:0] cand_idx;
    logic             grant_found;
    logic             grant;
    logic             slot_free;
    logic             handshake;

    assign slot_free = !pkt_valid_o || pkt_ready_i;
    assign handshake = pkt_valid_o && pkt_ready_i;

    // Rotating search starting at ptr_q; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            cand_idx = SRC_W'((32'(ptr_q) + i) % NREQ_U);
            if (!grant_found && req_valid_i[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign grant = (state_q == ST_RUN) && slot_free && grant_found;

    always_comb begin
        req_ready_o = '0;
        if (grant) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_done_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    state_d = ST_FLUSH;
                end else if (enable_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_FLUSH;
                end else if (!enable_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                // No grants here, so a free slot means the register is
                // empty at the next edge (including via this cycle's handshake).
                if (slot_free) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                flush_done_o = 1'b1;
                state_d      = enable_i ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_valid_o <= 1'b0;
            pkt_data_o  <= '0;
            pkt_src_o   <= '0;
            ptr_q       <= '0;
        end else if (grant) begin
            pkt_valid_o <= 1'b1;
            pkt_data_o  <= req_packet_i[32'(grant_idx)*PKT_W +: PKT_W];
            pkt_src_o   <= grant_idx;
            ptr_q       <= (32'(grant_idx) == NREQ_U - 1) ? '0 : grant_idx + 1'b1;
        end else if (handshake) begin
            pkt_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clr_i) begin
            pkt_count_o <= '0;
        end else if (handshake && (pkt_count_o != '1)) begin
            pkt_count_o <= pkt_count_o + 1'b1;
        end
    end

    assign busy_o = pkt_valid_o || (state_q == ST_FLUSH);

endmodule
